// File: rtl/pool_out_packer_if.sv
// Write port from the pooling output packer to the output feature-map buffer.
interface pool_out_packer_if #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_W     = 128
);
   logic                  wr_valid_o;
   logic                  wr_ready_i;
   logic [ADDR_WIDTH-1:0] wr_addr_o;
   logic [DATA_W-1:0]     wr_data_o;
   logic                  wr_last_o;

   modport master (
      output wr_valid_o,
      output wr_addr_o,
      output wr_data_o,
      output wr_last_o,
      input  wr_ready_i
   );

   modport slave (
      input  wr_valid_o,
      input  wr_addr_o,
      input  wr_data_o,
      input  wr_last_o,
      output wr_ready_i
   );
endinterface

// File: rtl/pool_out_packer.sv
// Buffers unstallable pooling lanes in per-lane FIFOs and packs one entry per
// lane into an addressed valid/ready write beat to the output buffer.
module pool_out_packer #(
   parameter int unsigned POOL_NUM   = 16,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [POOL_NUM-1:0]                 pool_last_i,
   input  logic [POOL_NUM-1:0]                 pool_valid_i,
   input  logic [POOL_NUM-1:0][DATA_WIDTH-1:0] pool_result_i,
   input  logic                                start_i,
   input  logic [ADDR_WIDTH-1:0]               base_addr_i,
   pool_out_packer_if.master                   wr,
   output logic                                busy_o,
   output logic                                done_o,
   output logic                                overflow_o,
   output logic                                misalign_o
);
   localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W  = IDX_W + 1;
   localparam int unsigned ENT_W  = DATA_WIDTH + 1;
   localparam int unsigned WORD_W = POOL_NUM * DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [ENT_W-1:0]  r_mem  [POOL_NUM][FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr [POOL_NUM];
   logic [PTR_W-1:0]  r_rptr [POOL_NUM];

   logic              r_wr_valid;
   logic              r_wr_last;
   logic [WORD_W-1:0] r_wr_data;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic              r_busy;
   logic              r_done;
   logic              r_overflow;
   logic              r_misalign;

   logic [POOL_NUM-1:0] w_empty;
   logic [POOL_NUM-1:0] w_full;
   logic [POOL_NUM-1:0] w_push;
   logic [POOL_NUM-1:0] w_pop_last;
   logic [WORD_W-1:0]   w_pop_data;
   logic                w_accept;
   logic                w_pop;
   logic                w_start;
   logic                w_ovf;
   logic                w_mis;

   // FIFO status and head-of-line entries for every lane
   always_comb begin
      w_empty    = '0;
      w_full     = '0;
      w_pop_last = '0;
      w_pop_data = '0;
      for (int i = 0; i < POOL_NUM; i++) begin
         w_empty[i]    = (r_wptr[i] == r_rptr[i]);
         w_full[i]     = (r_wptr[i] == (r_rptr[i] ^ PTR_W'(FIFO_DEPTH)));
         w_pop_last[i] = r_mem[i][r_rptr[i][IDX_W-1:0]][DATA_WIDTH];
         w_pop_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i][r_rptr[i][IDX_W-1:0]][DATA_WIDTH-1:0];
      end
   end

   // A held last beat blocks further pops so trailing entries stay for the next tile
   assign w_accept = r_wr_valid & wr.wr_ready_i;
   assign w_start  = (r_state == S_IDLE) & start_i;
   assign w_pop    = (r_state == S_RUN) & (&(~w_empty)) & (~r_wr_valid | w_accept)
                   & ~(r_wr_valid & r_wr_last);
   assign w_push   = pool_valid_i & (~w_full | {POOL_NUM{w_pop}});
   assign w_ovf    = |(pool_valid_i & w_full & ~{POOL_NUM{w_pop}});
   assign w_mis    = w_pop & (|w_pop_last) & ~(&w_pop_last);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start_i) w_next = S_RUN;
         S_RUN:   if (w_accept && r_wr_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < POOL_NUM; i++) begin
            r_wptr[i] <= '0;
            r_rptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < POOL_NUM; i++) begin
            if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
            if (w_pop)     r_rptr[i] <= r_rptr[i] + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < POOL_NUM; i++) begin
         if (w_push[i]) r_mem[i][r_wptr[i][IDX_W-1:0]] <= {pool_last_i[i], pool_result_i[i]};
      end
   end

   // Output beat register, address counter and sticky status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_valid <= 1'b0;
         r_wr_last  <= 1'b0;
         r_wr_data  <= '0;
         r_addr     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         if (w_pop) begin
            r_wr_valid <= 1'b1;
            r_wr_data  <= w_pop_data;
            r_wr_last  <= &w_pop_last;
         end else if (w_accept) begin
            r_wr_valid <= 1'b0;
            r_wr_last  <= 1'b0;
         end
         if (w_start)       r_addr <= base_addr_i;
         else if (w_accept) r_addr <= r_addr + ADDR_WIDTH'(1);
         r_overflow <= (r_overflow & ~w_start) | w_ovf;
         r_misalign <= (r_misalign & ~w_start) | w_mis;
         r_busy     <= (w_next == S_RUN);
         r_done     <= (w_next == S_DONE);
      end
   end

   assign wr.wr_valid_o = r_wr_valid;
   assign wr.wr_addr_o  = r_addr;
   assign wr.wr_data_o  = r_wr_data;
   assign wr.wr_last_o  = r_wr_last;
   assign busy_o        = r_busy;
   assign done_o        = r_done;
   assign overflow_o    = r_overflow;
   assign misalign_o    = r_misalign;
endmodule

// File: doc/pool_out_packer.md
Name: pool_out_packer

Overview:
- Sits directly downstream of the 16-lane pooling array and consumes its per-lane pool_last/pool_valid/pool_result streams.
- Buffers each lane in a small FIFO, because the pooling lanes have no backpressure.
- Packs one entry from every lane into a POOL_NUM*DATA_WIDTH word and writes it to the output feature-map buffer through a valid/ready port with an auto-incrementing address.
- Flags overflow and lane misalignment.

Parameters:
- POOL_NUM, 16, number of pooling lanes packed per word.
- DATA_WIDTH, 8, bits per pooled result.
- FIFO_DEPTH, 8, entries per lane FIFO (power of 2, >=2).
- ADDR_WIDTH, 10, output buffer word-address width.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- pool_last_i  input  1 [POOL_NUM]  per-lane last-of-tile marker.
- pool_valid_i  input  1 [POOL_NUM]  per-lane result valid; there is no ready, so input cannot be stalled.
- pool_result_i  input  DATA_WIDTH [POOL_NUM]  per-lane pooled value.
- start_i  input  1  one-cycle pulse that begins a tile write.
- base_addr_i  input  ADDR_WIDTH  first word address, sampled on an accepted start_i.
- wr_valid_o  output  1  write beat valid.
- wr_ready_i  input  1  output buffer accepts the beat.
- wr_addr_o  output  ADDR_WIDTH  word address of the current beat.
- wr_data_o  output  POOL_NUM*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_last_o  output  1  final beat of the tile.
- busy_o  output  1  high in RUN.
- done_o  output  1  one-cycle pulse after the last beat is accepted.
- overflow_o  output  1  sticky: some lane pushed while full.
- misalign_o  output  1  sticky: popped entries disagreed on their last bit.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, all FIFOs empty, address counter 0, all outputs 0. Reset mid-tile discards all buffered data; there is no partial flush.
- Push: in any state, pool_valid_i[i] writes {pool_last_i[i], pool_result_i[i]} into FIFO i. The entry is visible (non-empty) the next cycle.
- Push to a full FIFO with no same-cycle pop: the entry is dropped and overflow_o is set.
- Push to a full FIFO with a same-cycle pop: the entry is accepted, with no overflow.
- Beat acceptance: accept = wr_valid_o & wr_ready_i.
- Pop condition (RUN only): every FIFO is non-empty AND (wr_valid_o==0 OR accept). When it holds, all lanes pop together and the output register loads at the next edge:
  - wr_valid_o=1;
  - wr_data_o=packed data;
  - wr_last_o=AND of the popped last bits.
- Misalignment: if the popped last bits are not all equal, misalign_o is set. wr_last_o is still the AND.
- Hold: while wr_valid_o=1 and wr_ready_i=0, wr_data_o, wr_addr_o and wr_last_o stay stable.
- Drop of wr_valid_o: accept with no pop in the same cycle clears wr_valid_o at the next edge.
- Latency: all lanes push in cycle N; pop in cycle N+1; wr_valid_o=1 in cycle N+2. Sustained throughput is 1 beat/cycle while wr_ready_i=1 and no FIFO runs empty.
- Address: wr_addr_o = base_addr_i for the first beat, then +1 per accept. It wraps modulo 2^ADDR_WIDTH with no flag.
- FSM states:
  - IDLE: start_i loads the address counter and clears overflow_o and misalign_o, then goes to RUN. FIFOs may fill while in IDLE; nothing pops.
  - RUN: busy_o=1. Accept of a beat with wr_last_o=1 goes to DONE. No further pops occur after the last beat has been loaded into the output register.
  - DONE: done_o=1 for exactly one cycle, wr_valid_o=0, then IDLE.
- start_i outside IDLE is ignored.
- Entries beyond the last beat stay in the FIFOs for the next tile.

Test Plan:
- Reset/basic: release rst; all 16 lanes push values i+1 in cycle 0, base_addr_i=0x010, start_i already accepted -> wr_valid_o rises in cycle 2, wr_addr_o=0x010, wr_data_o byte i = i+1.
- Tile completion: 4 pushes per lane, the 4th with last=1, wr_ready_i=1 -> 4 consecutive beats at addrs 0x010..0x013; wr_last_o only on the 4th; done_o pulses the cycle after; busy_o drops.
- Backpressure/skew: lane 15 delayed 3 cycles; wr_ready_i low for 5 cycles -> no beat until lane 15 data arrives; data and addr held stable while stalled; no loss.
- Overflow: wr_ready_i=0 and 9 pushes per lane (FIFO_DEPTH=8) -> overflow_o=1, 9th value absent from the output; next start_i clears overflow_o.
- Full+pop same cycle: FIFO full, accept and push coincide -> overflow_o stays 0 and the pushed value appears in order.
- Misalign/wrap: base_addr_i=0x3FF with lane 3 last=1 on the first beat only -> addrs 0x3FF then 0x000; misalign_o=1; wr_last_o=0. Asserting rst mid-tile -> all outputs return to 0 and FIFOs are empty.
